// File: rtl/uart_pkg.sv
// Shared UART framing definitions for the multiplier transmitter and the
// product receiver, so both ends agree on the bit period and the frame format.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 4;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/product_uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// reset to RESET_VAL so the synchronised line starts in a known state.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/product_uart_rx.sv
// 8N1 UART receiver that recovers the multiplier product from its serial
// output, sampling each bit at mid-bit from a programmable bit period.
module product_uart_rx #(
    parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] product,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W   = $clog2(DATA_BITS);
    localparam logic [TIMER_W-1:0] HALF_CNT = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_CNT = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q,   state_d;
    logic [TIMER_W-1:0]   timer_q,   timer_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] product_q, product_d;
    logic                 valid_q,   valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q,    busy_d;
    logic                 rxs_s;
    logic                 half_tick_s;
    logic                 bit_tick_s;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk_i (CLK),
        .rst_i (rst),
        .d_i   (rx),
        .q_o   (rxs_s)
    );

    assign half_tick_s = (timer_q == HALF_CNT);
    assign bit_tick_s  = (timer_q == FULL_CNT);

    // State register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a high line at mid start bit is treated as a glitch
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rxs_s) state_d = START;
                else        state_d = IDLE;
            end
            START: begin
                if (half_tick_s) state_d = rxs_s ? IDLE : DATA;
                else             state_d = START;
            end
            DATA: begin
                if (bit_tick_s && (bit_idx_q == LAST_IDX)) state_d = STOP;
                else                                       state_d = DATA;
            end
            STOP: begin
                if (bit_tick_s) state_d = rxs_s ? IDLE : BREAK;
                else            state_d = STOP;
            end
            BREAK: begin
                if (rxs_s) state_d = IDLE;
                else       state_d = BREAK;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timer, bit index, shift register and product holding register
    always_comb begin
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                timer_d   = TIMER_W'(0);
                bit_idx_d = IDX_W'(0);
            end
            START: begin
                if (half_tick_s) begin
                    timer_d   = TIMER_W'(0);
                    bit_idx_d = IDX_W'(0);
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            DATA: begin
                if (bit_tick_s) begin
                    timer_d   = TIMER_W'(0);
                    shift_d   = {rxs_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            STOP: begin
                if (bit_tick_s) begin
                    timer_d = TIMER_W'(0);
                    if (rxs_s) product_d = shift_q;
                    else       product_d = product_q;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            BREAK:   timer_d = TIMER_W'(0);
            default: timer_d = TIMER_W'(0);
        endcase
    end

    // Output decode; pulses are registered so they align with the IDLE return
    always_comb begin
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        if ((state_q == STOP) && bit_tick_s) begin
            valid_d     = rxs_s;
            frame_err_d = ~rxs_s;
        end else begin
            valid_d     = 1'b0;
            frame_err_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            timer_q     <= TIMER_W'(0);
            bit_idx_q   <= IDX_W'(0);
            shift_q     <= DATA_BITS'(0);
            product_q   <= DATA_BITS'(0);
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            product_q   <= product_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign product   = product_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_product_uart_rx.sv
// Scoreboard bench for product_uart_rx: the driver queues expected bytes and
// start times, a monitor checks every valid / frame_err pulse as it appears.
module tb_product_uart_rx;

    localparam int CPB = 4;
    localparam int DB  = 8;

    logic          CLK = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic [DB-1:0] product;
    logic          valid;
    logic          frame_err;
    logic          busy;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [DB-1:0] exp_prod_q[$];
    int            exp_lat_q[$];
    int            exp_ferr  = 0;
    logic [DB-1:0] last_good = 8'h00;

    product_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .rx        (rx),
        .product   (product),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge CLK);
        rx = b;
        repeat (CPB - 1) @(negedge CLK);
    endtask

    // good=1: normal stop bit, expect a valid; good=0: stop bit low, expect frame_err
    task automatic send_frame(input logic [DB-1:0] d, input logic good);
        @(negedge CLK);
        rx = 1'b0;
        if (good) begin
            exp_prod_q.push_back(d);
            exp_lat_q.push_back(cyc);
        end else begin
            exp_ferr++;
        end
        repeat (CPB - 1) @(negedge CLK);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        send_bit(good);
    endtask

    // Monitor: compares every output pulse against the scoreboard
    always @(negedge CLK) begin
        if (!rst) begin
            if (valid) begin
                check("valid_ferr_exclusive", {31'd0, frame_err}, 32'd0);
                check("busy_drops_with_valid", {31'd0, busy}, 32'd0);
                if (exp_prod_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: product 0x%0h, no frame expected", product);
                end else begin
                    logic [DB-1:0] e;
                    int lat;
                    e   = exp_prod_q.pop_front();
                    lat = cyc - exp_lat_q.pop_front();
                    check("product", {24'd0, product}, {24'd0, e});
                    last_good = e;
                    n_checks++;
                    if (lat < 40 || lat > 42) begin
                        n_fail++;
                        $display("FAIL latency: got %0d cycles required 40..42", lat);
                    end
                end
            end
            if (frame_err) begin
                if (exp_ferr == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame_err: count got 1 required 0");
                end else begin
                    exp_ferr--;
                    check("product_held_on_ferr", {24'd0, product}, {24'd0, last_good});
                end
            end
        end
    end

    initial begin
        logic          seen;
        logic [DB-1:0] partial;

        rst = 1'b1;
        rx  = 1'b1;
        #2;
        check("reset_product", {24'd0, product}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        #8;
        rst = 1'b0;

        // Idle line for 20 bit-times
        seen = 1'b0;
        repeat (20 * CPB) begin
            @(negedge CLK);
            seen = seen | valid | frame_err | busy;
        end
        check("idle_quiet", {31'd0, seen}, 32'd0);
        check("idle_product", {24'd0, product}, 32'd0);

        // Single frame
        send_frame(8'hF2, 1'b1);
        repeat (2 * CPB) @(negedge CLK);
        check("product_after_F2", {24'd0, product}, 32'h0000_00F2);

        // Back-to-back frames, no idle gap
        send_frame(8'h62, 1'b1);
        send_frame(8'h0E, 1'b1);
        repeat (2 * CPB) @(negedge CLK);
        check("product_after_b2b", {24'd0, product}, 32'h0000_000E);

        // Bad stop bit, line held low for 3 bit-times total
        send_frame(8'hA5, 1'b0);
        repeat (2 * CPB) @(negedge CLK);
        check("busy_in_break", {31'd0, busy}, 32'd1);
        @(negedge CLK);
        rx = 1'b1;
        repeat (4) @(negedge CLK);
        check("busy_after_break", {31'd0, busy}, 32'd0);
        check("product_after_ferr", {24'd0, product}, 32'h0000_000E);

        // One-cycle glitch in IDLE
        @(negedge CLK);
        rx = 1'b0;
        @(negedge CLK);
        rx = 1'b1;
        seen = 1'b0;
        repeat (3 * CPB) begin
            @(negedge CLK);
            seen = seen | busy;
        end
        check("false_start_busy_pulse", {31'd0, seen}, 32'd1);
        check("false_start_idle", {31'd0, busy}, 32'd0);
        check("false_start_product", {24'd0, product}, 32'h0000_000E);

        // Reset after 4 data bits of 0x3C, then a clean frame
        partial = 8'h3C;
        @(negedge CLK);
        rx = 1'b0;
        repeat (CPB - 1) @(negedge CLK);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        @(negedge CLK);
        rst = 1'b1;
        rx  = 1'b1;
        last_good = 8'h00;
        #1;
        check("midreset_product", {24'd0, product}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_valid", {31'd0, valid}, 32'd0);
        #10;
        @(negedge CLK);
        rst = 1'b0;
        repeat (10) @(negedge CLK);
        check("after_reset_product", {24'd0, product}, 32'd0);
        send_frame(8'h81, 1'b1);
        repeat (3 * CPB) @(negedge CLK);
        check("product_after_81", {24'd0, product}, 32'h0000_0081);

        check("pending_valids", exp_prod_q.size(), 32'd0);
        check("pending_frame_errs", exp_ferr, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
